// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I run controller: FSM state encoding,
// environment-call instruction encodings and the register-index type.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef logic [4:0] reg_idx_t;

  function automatic logic is_env_call(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/halt_detect.sv
// Program-end detector: flags a halt on ECALL/EBREAK or when the PC has stayed
// unchanged long enough to be a self-loop. Only evaluates while active.
module halt_detect
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  output logic            halt
);

  localparam int REP_W = $clog2(HALT_REPEAT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             prev_valid_q, prev_valid_d;
  logic [REP_W-1:0] rep_q, rep_d;

  // prev_valid stops a stale PC from the last run (or reset value) matching
  // the first PC of a new run.
  always_comb begin
    prev_pc_d    = prev_pc_q;
    prev_valid_d = 1'b0;
    rep_d        = '0;
    if (active) begin
      prev_pc_d    = pc;
      prev_valid_d = 1'b1;
      if (prev_valid_q && (pc == prev_pc_q)) begin
        rep_d = (rep_q == REP_LAST) ? rep_q : rep_q + 1'b1;
      end
    end
    halt = active && (is_env_call(instr) || (rep_d == REP_LAST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      rep_q        <= '0;
    end else begin
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      rep_q        <= rep_d;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RV32I core: sequences core reset, counts
// run cycles and retired instructions, detects program end, produces a verdict.
module core_run_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 4,
  parameter int TRACK_REG   = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  expected,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             reg_we,
  input  reg_idx_t         reg_waddr,
  input  logic [XLEN-1:0]  reg_wdata,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic [XLEN-1:0]  result,
  output run_state_e       dbg_state
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam reg_idx_t         TRACK_IDX = reg_idx_t'(TRACK_REG);

  run_state_e       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  expected_q, expected_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  halt_detect #(
    .XLEN        (XLEN),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk    (clk),
    .rst    (rst),
    .active (state_q == ST_RUN),
    .pc     (pc),
    .instr  (instr),
    .halt   (halt)
  );

  // start is a single-cycle request with no ready: it is accepted only in
  // IDLE or DONE and silently dropped in every other state.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    result_d    = result_q;
    expected_d  = expected_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          expected_d  = expected;
          cycle_cnt_d = '0;
          instret_d   = '0;
          result_d    = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          rst_cnt_d   = '0;
          state_d     = ST_RESET;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        instret_d   = sat_inc(instret_q);
        if (reg_we && (reg_waddr != '0) && (reg_waddr == TRACK_IDX)) begin
          result_d = reg_wdata;
        end
        // Halt takes priority so a program ending on the last budget cycle passes.
        if (halt) begin
          timeout_d = 1'b0;
          state_d   = ST_CHECK;
        end else if (cycle_cnt_d >= MAX_CNT) begin
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pass_d  = !timeout_q && (result_q == expected_q);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
      result_q    <= '0;
      expected_q  <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
      result_q    <= result_d;
      expected_q  <= expected_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  // Core is held in reset everywhere except RUN, which also freezes it after a verdict.
  assign core_rst      = (state_q != ST_RUN);
  assign running       = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_cnt_q;
  assign instret_count = instret_q;
  assign result        = result_q;
  assign dbg_state     = state_q;

endmodule
